// File: rtl/regfile_mp.sv
// Multi-port integer register file with zeroing sweep after reset and busy scoreboard.
// Optional same-cycle write-to-read forwarding under `REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      run,
    output logic                      ready,
    input  logic [NRD*$clog2(NREGS)-1:0] raddr,
    output logic [NRD*XLEN-1:0]       rdata,
    output logic [NRD-1:0]            rbusy,
    input  logic [NWR*$clog2(NREGS)-1:0] waddr,
    input  logic [NWR*XLEN-1:0]       wdata,
    input  logic [NWR-1:0]            we,
    input  logic [NWR-1:0]            wclr,
    input  logic [$clog2(NREGS)-1:0]  iss_addr,
    input  logic                      iss_vld,
    output logic [NREGS-1:0]          busy
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state;
    logic [AW-1:0]     cnt;
    logic [XLEN-1:0]   mem [NREGS];
    logic [NREGS-1:0]  busy_nxt;
    logic              active;

    assign active = (state == S_READY) && run;
    assign ready  = (state == S_READY);

    // Sweep sequencer: INIT walks every address once, then READY until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else if (state == S_INIT) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(NREGS - 1)) begin
                state <= S_READY;
            end
        end
    end

    // Storage: zeroed by the sweep; later ports overwrite earlier ones on address collision.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[cnt] <= '0;
        end else if (run) begin
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && waddr[w*AW +: AW] != '0) begin
                    mem[waddr[w*AW +: AW]] <= wdata[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard update: clears first so a same-cycle issue (new producer) wins.
    always_comb begin
        busy_nxt = busy;
        if (active) begin
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && wclr[w]) begin
                    busy_nxt[waddr[w*AW +: AW]] = 1'b0;
                end
            end
            if (iss_vld && iss_addr != '0) begin
                busy_nxt[iss_addr] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Combinational read ports; x0 and the INIT phase always read as zero.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int r = 0; r < NRD; r++) begin
            if (state == S_READY && raddr[r*AW +: AW] != '0) begin
                rdata[r*XLEN +: XLEN] = mem[raddr[r*AW +: AW]];
                rbusy[r]              = busy[raddr[r*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NWR; w++) begin
                    if (active && we[w] && waddr[w*AW +: AW] == raddr[r*AW +: AW]) begin
                        rdata[r*XLEN +: XLEN] = wdata[w*XLEN +: XLEN];
                        rbusy[r]              = busy[raddr[r*AW +: AW]] & ~wclr[w];
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic vs an array model.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic                 clk;
    logic                 reset_n;
    logic                 run;
    logic                 ready;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;
    logic [NWR*AW-1:0]    waddr;
    logic [NWR*XLEN-1:0]  wdata;
    logic [NWR-1:0]       we;
    logic [NWR-1:0]       wclr;
    logic [AW-1:0]        iss_addr;
    logic                 iss_vld;
    logic [NREGS-1:0]     busy;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [XLEN-1:0] m_mem [NREGS];
    logic            m_busy [NREGS];
    bit              m_ready;
    int              m_cnt;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .ready(ready),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .waddr(waddr), .wdata(wdata), .we(we), .wclr(wclr),
        .iss_addr(iss_addr), .iss_vld(iss_vld), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        run = 1'b1; we = '0; wclr = '0; waddr = '0; wdata = '0;
        iss_vld = 1'b0; iss_addr = '0; raddr = '0;
    endtask

    task automatic drive_wr(input int p, input int a, input logic [31:0] d, input bit en, input bit clr);
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*XLEN +: XLEN] = d;
        we[p] = en;
        wclr[p] = clr;
    endtask

    // Advance one clock, applying the architectural rules to the model.
    task automatic tick();
        int a;
        if (m_ready && run) begin
            for (int w = 0; w < NWR; w++) begin
                a = int'(waddr[w*AW +: AW]);
                if (we[w] && a != 0) m_mem[a] = wdata[w*XLEN +: XLEN];
            end
            for (int w = 0; w < NWR; w++) begin
                a = int'(waddr[w*AW +: AW]);
                if (we[w] && wclr[w]) m_busy[a] = 1'b0;
            end
            if (iss_vld && iss_addr != 0) m_busy[int'(iss_addr)] = 1'b1;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == NREGS) m_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        run = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_ready = 1'b0;
        m_cnt = 0;
        #3;
        total++;
        if (ready !== 1'b0 || busy !== '0) begin
            bad++;
            $display("FAIL reset_assert: ready=%b busy=%h expected ready=0 busy=0", ready, busy);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic void exp_read(input int p, output logic [31:0] d, output logic b);
        int a;
        a = int'(raddr[p*AW +: AW]);
        d = '0;
        b = 1'b0;
        if (m_ready && a != 0) begin
            d = m_mem[a];
            b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (run) begin
                for (int w = 0; w < NWR; w++) begin
                    if (we[w] && int'(waddr[w*AW +: AW]) == a) begin
                        d = wdata[w*XLEN +: XLEN];
                        b = m_busy[a] & ~wclr[w];
                    end
                end
            end
`endif
        end
    endfunction

    // Reset (optionally interrupted mid-sweep), sweep length, and zeroed contents.
    task automatic test_reset(input int pre_cycles);
        do_reset();
        if (pre_cycles > 0) begin
            for (int i = 0; i < pre_cycles; i++) tick();
            do_reset();
        end
        for (int k = 0; k < NREGS; k++) begin
            raddr = AW'(k) ;
            #1;
            total++;
            if (ready !== 1'b0 || rdata[31:0] !== 32'h0 || rbusy !== 2'b00) begin
                bad++;
                $display("FAIL sweep_cycle%0d: ready=%b rdata0=%h rbusy=%b expected 0/0/0", k, ready, rdata[31:0], rbusy);
            end
            tick();
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_sweep: ready=%b expected 1", ready);
        end
        run = 1'b1;
        for (int a = 0; a < NREGS; a++) begin
            raddr = {AW'(NREGS - 1 - a), AW'(a)};
            #1;
            total++;
            if (rdata !== '0 || busy !== '0) begin
                bad++;
                $display("FAIL zero_read_r%0d: rdata=%h busy=%h expected 0", a, rdata, busy);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        idle();
        drive_wr(0, 5, 32'hDEADBEEF, 1'b1, 1'b0);
        tick();
        idle();
        raddr[0 +: AW] = 5'd5;
        #1;
        total++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_read_r5: got %h expected DEADBEEF", rdata[31:0]);
        end
        drive_wr(0, 0, 32'h1, 1'b1, 1'b0);
        tick();
        idle();
        raddr = {5'd0, 5'd0};
        #1;
        total++;
        if (rdata !== '0) begin
            bad++;
            $display("FAIL write_x0: got %h expected 0", rdata);
        end
    endtask

    task automatic test_port_conflict();
        idle();
        drive_wr(0, 7, 32'h11, 1'b1, 1'b0);
        drive_wr(1, 7, 32'h22, 1'b1, 1'b0);
        tick();
        idle();
        raddr[AW +: AW] = 5'd7;
        #1;
        total++;
        if (rdata[63:32] !== 32'h22) begin
            bad++;
            $display("FAIL port_conflict_r7: got %h expected 22", rdata[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_vld = 1'b1; iss_addr = 5'd9;
        tick();
        idle();
        raddr[0 +: AW] = 5'd9;
        #1;
        total++;
        if (busy[9] !== 1'b1 || rbusy[0] !== 1'b1) begin
            bad++;
            $display("FAIL issue_busy9: busy9=%b rbusy0=%b expected 1/1", busy[9], rbusy[0]);
        end
        drive_wr(1, 9, 32'h99, 1'b1, 1'b1);
        tick();
        idle();
        total++;
        if (busy[9] !== 1'b0) begin
            bad++;
            $display("FAIL clear_busy9: got %b expected 0", busy[9]);
        end
        iss_vld = 1'b1; iss_addr = 5'd9;
        tick();
        idle();
        drive_wr(0, 9, 32'h98, 1'b1, 1'b1);
        iss_vld = 1'b1; iss_addr = 5'd9;
        tick();
        idle();
        total++;
        if (busy[9] !== 1'b1) begin
            bad++;
            $display("FAIL set_wins_busy9: got %b expected 1", busy[9]);
        end
        iss_vld = 1'b1; iss_addr = 5'd0;
        tick();
        idle();
        total++;
        if (busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL busy0_const: got %b expected 0", busy[0]);
        end
    endtask

    task automatic test_run_hold();
        idle();
        drive_wr(0, 3, 32'h33, 1'b1, 1'b0);
        tick();
        idle();
        run = 1'b0;
        drive_wr(0, 3, 32'h99, 1'b1, 1'b0);
        iss_vld = 1'b1; iss_addr = 5'd4;
        raddr[0 +: AW] = 5'd3;
        #1;
        total++;
        if (rdata[31:0] !== 32'h33) begin
            bad++;
            $display("FAIL run0_read_r3: got %h expected 33", rdata[31:0]);
        end
        tick();
        idle();
        raddr[0 +: AW] = 5'd3;
        #1;
        total++;
        if (rdata[31:0] !== 32'h33 || busy[4] !== 1'b0) begin
            bad++;
            $display("FAIL run0_hold: r3=%h busy4=%b expected 33/0", rdata[31:0], busy[4]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_now;
        idle();
`ifdef REGFILE_BYPASS_EN
        exp_now = 32'hCAFE;
`else
        exp_now = 32'h0;
`endif
        drive_wr(0, 12, 32'hCAFE, 1'b1, 1'b0);
        raddr[AW +: AW] = 5'd12;
        #1;
        total++;
        if (rdata[63:32] !== exp_now) begin
            bad++;
            $display("FAIL bypass_same_cycle: got %h expected %h", rdata[63:32], exp_now);
        end
        tick();
        idle();
        raddr[AW +: AW] = 5'd12;
        #1;
        total++;
        if (rdata[63:32] !== 32'hCAFE) begin
            bad++;
            $display("FAIL bypass_next_cycle: got %h expected CAFE", rdata[63:32]);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] ed;
        logic        eb;
        logic [NREGS-1:0] ebusy;
        int errs;
        for (int c = 0; c < n; c++) begin
            run = ($urandom_range(9) != 0);
            for (int w = 0; w < NWR; w++) begin
                drive_wr(w, int'($urandom_range(7)), $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            end
            iss_vld = 1'($urandom_range(1));
            iss_addr = AW'($urandom_range(7));
            raddr = {AW'($urandom_range(7)), AW'($urandom_range(NREGS - 1))};
            #1;
            errs = 0;
            for (int p = 0; p < NRD; p++) begin
                exp_read(p, ed, eb);
                total++;
                if (rdata[p*XLEN +: XLEN] !== ed || rbusy[p] !== eb) begin
                    bad++;
                    errs++;
                    if (errs < 4)
                        $display("FAIL rand_read c%0d p%0d: rdata=%h rbusy=%b expected %h/%b",
                                 c, p, rdata[p*XLEN +: XLEN], rbusy[p], ed, eb);
                end
            end
            for (int i = 0; i < NREGS; i++) ebusy[i] = m_busy[i];
            total++;
            if (busy !== ebusy) begin
                bad++;
                $display("FAIL rand_busy c%0d: got %h expected %h", c, busy, ebusy);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b1;
        test_reset(0);
        test_write_read();
        test_port_conflict();
        test_scoreboard();
        test_run_hold();
        test_bypass();
        test_random(400);
        test_reset(10);
        test_random(100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
